// File: rtl/packet_serializer.sv
// rtl/packet_serializer.sv - data island packet serializer with BCH ECC parity
//
// Serializes a 24-bit header and four 56-bit subpackets over 32 pixel clocks,
// appending 8 parity bits to the header and to each subpacket.
//
// Ports:
//   clk_pixel          pixel clock, all state on rising edge
//   reset              synchronous, active-high
//   data_island_period high while a packet slot is active
//   header             HB2:HB1:HB0, bit 0 transmitted first
//   sub                four subpackets, bit 0 transmitted first
//   packet_data        [0] header bit, [4:1] even sub bits, [8:5] odd sub bits
//   packet_valid       packet_data holds a live packet bit
//   packet_loaded      one-cycle pulse after header/sub were captured
//   counter            slot index most recently emitted
module packet_serializer (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [8:0]       packet_data,
    output logic             packet_valid,
    output logic             packet_loaded,
    output logic [4:0]       counter
);

    logic [4:0]       k;
    logic [23:0]      header_shadow;
    logic [3:0][55:0] sub_shadow;
    logic [7:0]       ecc_header;
    logic [3:0][7:0]  ecc_sub;

    logic             first_slot;
    logic [23:0]      cur_header;
    logic [3:0][55:0] cur_sub;
    logic [7:0]       ecc_header_cur;
    logic [7:0]       ecc_header_next;
    logic [3:0][7:0]  ecc_sub_cur;
    logic [3:0][7:0]  ecc_sub_next;
    logic             header_bit;
    logic [3:0]       even_bits;
    logic [3:0]       odd_bits;

    // One bit-serial step of x^8+x^7+x^6+1, LSB first.
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        if (e[0] ^ b) begin
            return (e >> 1) ^ 8'h83;
        end
        return e >> 1;
    endfunction

    always_comb begin
        // Slot 0 works from the live inputs and a zero ECC seed, so a new
        // packet never depends on what was left over from the previous one.
        first_slot      = (k == 5'd0);
        cur_header      = first_slot ? header : header_shadow;
        cur_sub         = first_slot ? sub : sub_shadow;
        ecc_header_cur  = first_slot ? 8'h00 : ecc_header;
        ecc_sub_cur     = first_slot ? '0 : ecc_sub;
        ecc_header_next = ecc_header_cur;
        ecc_sub_next    = ecc_sub_cur;
        header_bit      = 1'b0;
        even_bits       = '0;
        odd_bits        = '0;

        if (k < 5'd24) begin
            header_bit      = cur_header[k];
            ecc_header_next = ecc_step(ecc_header_cur, cur_header[k]);
        end else begin
            // Slots 24..31 map to parity bit k-24, which is simply k[2:0].
            header_bit = ecc_header_cur[k[2:0]];
        end

        for (int i = 0; i < 4; i++) begin
            if (k < 5'd28) begin
                even_bits[i]    = cur_sub[i][{k, 1'b0}];
                odd_bits[i]     = cur_sub[i][{k, 1'b1}];
                ecc_sub_next[i] = ecc_step(ecc_step(ecc_sub_cur[i], cur_sub[i][{k, 1'b0}]),
                                           cur_sub[i][{k, 1'b1}]);
            end else begin
                // Slots 28..31: k-28 is k[1:0].
                even_bits[i] = ecc_sub_cur[i][{k[1:0], 1'b0}];
                odd_bits[i]  = ecc_sub_cur[i][{k[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            packet_data   <= '0;
            packet_valid  <= 1'b0;
            packet_loaded <= 1'b0;
            counter       <= '0;
            k             <= '0;
            header_shadow <= '0;
            sub_shadow    <= '0;
            ecc_header    <= '0;
            ecc_sub       <= '0;
        end else if (data_island_period) begin
            packet_data   <= {odd_bits, even_bits, header_bit};
            packet_valid  <= 1'b1;
            packet_loaded <= first_slot;
            counter       <= k;
            k             <= k + 5'd1;
            ecc_header    <= ecc_header_next;
            ecc_sub       <= ecc_sub_next;
            if (first_slot) begin
                header_shadow <= header;
                sub_shadow    <= sub;
            end
        end else begin
            // Leaving the island mid-packet abandons it; counter holds.
            packet_data   <= '0;
            packet_valid  <= 1'b0;
            packet_loaded <= 1'b0;
            k             <= '0;
            ecc_header    <= '0;
            ecc_sub       <= '0;
        end
    end

endmodule

// File: tb/tb_packet_serializer.sv
// tb/tb_packet_serializer.sv - directed self-checking bench for packet_serializer
module tb_packet_serializer;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [8:0]       packet_data;
    logic             packet_valid;
    logic             packet_loaded;
    logic [4:0]       counter;

    int total = 0;
    int bad   = 0;

    logic [3:0][55:0] sub_zero;
    logic [3:0][55:0] sub_bit55;

    always #5 clk_pixel = ~clk_pixel;

    packet_serializer dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_data        (packet_data),
        .packet_valid       (packet_valid),
        .packet_loaded      (packet_loaded),
        .counter            (counter)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_pixel);
        #1;
    endtask

    // Drive nslots slots; header/sub switch to the *_rest values after slot 0.
    // eh/ee/eo give the expected header lane and lane-0 even/odd bit per slot.
    task automatic play(input string name,
                        input logic [23:0] h0, input logic [23:0] h_rest,
                        input logic [3:0][55:0] s0, input logic [3:0][55:0] s_rest,
                        input logic [31:0] eh, input logic [31:0] ee, input logic [31:0] eo,
                        input int nslots);
        for (int n = 0; n < nslots; n++) begin
            data_island_period = 1'b1;
            header = (n == 0) ? h0 : h_rest;
            sub    = (n == 0) ? s0 : s_rest;
            tick;
            check($sformatf("%s data s%0d", name, n), 64'(packet_data),
                  64'({3'b000, eo[n[4:0]], 3'b000, ee[n[4:0]], eh[n[4:0]]}));
            check($sformatf("%s valid s%0d", name, n), 64'(packet_valid), 64'd1);
            check($sformatf("%s counter s%0d", name, n), 64'(counter), 64'(n[4:0]));
            check($sformatf("%s loaded s%0d", name, n), 64'(packet_loaded), 64'(n == 0));
        end
    endtask

    task automatic idle(input string name, input logic [4:0] exp_counter);
        data_island_period = 1'b0;
        tick;
        check({name, " idle valid"}, 64'(packet_valid), 64'd0);
        check({name, " idle data"}, 64'(packet_data), 64'd0);
        check({name, " idle counter"}, 64'(counter), 64'(exp_counter));
        check({name, " idle loaded"}, 64'(packet_loaded), 64'd0);
    endtask

    initial begin
        sub_zero     = '0;
        sub_bit55    = '0;
        sub_bit55[0] = 56'h80_0000_0000_0000;

        reset = 1'b1;
        data_island_period = 1'b0;
        header = '0;
        sub = '0;
        tick;
        tick;
        check("reset data", 64'(packet_data), 64'd0);
        check("reset valid", 64'(packet_valid), 64'd0);
        check("reset loaded", 64'(packet_loaded), 64'd0);
        check("reset counter", 64'(counter), 64'd0);
        reset = 1'b0;
        tick;

        play("zero", 24'h0, 24'h0, sub_zero, sub_zero, 32'h0, 32'h0, 32'h0, 32);
        idle("zero", 5'd31);

        // Header bit 23 set: ECC 8'h83 -> slots 24,25,31 set, plus slot 23.
        play("hecc", 24'h800000, 24'h800000, sub_zero, sub_zero,
             32'h8380_0000, 32'h0, 32'h0, 32);
        idle("hecc", 5'd31);

        // sub[0] bit 55 (odd, slot 27); parity pairs (1,1),(0,0),(0,0),(0,1).
        // Inputs are zeroed after slot 0, so the shadow must carry the packet.
        play("secc", 24'h0, 24'h0, sub_bit55, sub_zero,
             32'h0, 32'h1000_0000, 32'h9800_0000, 32);
        idle("secc", 5'd31);

        play("shadow", 24'h800000, 24'h0, sub_zero, sub_zero,
             32'h8380_0000, 32'h0, 32'h0, 32);
        idle("shadow", 5'd31);

        // Back-to-back: loaded checked high only at slot 0 of each packet.
        play("b2b_a", 24'h800000, 24'h800000, sub_zero, sub_zero,
             32'h8380_0000, 32'h0, 32'h0, 32);
        play("b2b_b", 24'h0, 24'h0, sub_zero, sub_zero, 32'h0, 32'h0, 32'h0, 32);
        idle("b2b", 5'd31);

        // Abort after slot 9, then a full packet must restart at slot 0.
        play("abort_part", 24'h800000, 24'h800000, sub_zero, sub_zero,
             32'h8380_0000, 32'h0, 32'h0, 10);
        idle("abort", 5'd9);
        play("abort_full", 24'h800000, 24'h800000, sub_bit55, sub_bit55,
             32'h8380_0000, 32'h1000_0000, 32'h9800_0000, 32);
        idle("abort_full", 5'd31);

        // Reset mid-packet with the island still active.
        play("rst_part", 24'h800000, 24'h800000, sub_bit55, sub_bit55,
             32'h8380_0000, 32'h0, 32'h0, 5);
        reset = 1'b1;
        data_island_period = 1'b1;
        tick;
        check("midreset data", 64'(packet_data), 64'd0);
        check("midreset valid", 64'(packet_valid), 64'd0);
        check("midreset loaded", 64'(packet_loaded), 64'd0);
        check("midreset counter", 64'(counter), 64'd0);
        reset = 1'b0;
        play("after_rst", 24'h800000, 24'h800000, sub_zero, sub_zero,
             32'h8380_0000, 32'h0, 32'h0, 32);
        idle("after_rst", 5'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
# packet_serializer

Downstream stage of the packet generators: audio clock regeneration, audio sample, audio InfoFrame and other packet sources. It accepts one 24-bit header and four 56-bit subpackets and serializes them over 32 pixel clocks during a data island period. It appends the BCH ECC parity bytes (HDMI 1.4a Section 5.2.3.4) to the header and to each subpacket. It produces the 9 packet bits per clock that the TERC4 stage consumes: 1 header bit plus 4 even and 4 odd subpacket bits.

## Interface

Parameters: none.

Ports:

- clk_pixel  input  1  pixel clock; all state on rising edge
- reset  input  1  synchronous, active-high
- data_island_period  input  1  high while a data island packet slot is active
- header  input  24  packet header HB2:HB1:HB0; HB0 is in bits [7:0], transmitted bit 0 first
- sub  input  56 x [3:0]  subpackets; sub[i] bit 0 is transmitted first
- packet_data  output  9  bit 0 = header bit; bits [4:1] = even bit of sub[3:0]; bits [8:5] = odd bit of sub[3:0]
- packet_valid  output  1  packet_data holds a live packet bit
- packet_loaded  output  1  one-cycle pulse: header/sub were captured, so the upstream stage may present the next packet
- counter  output  5  index of the bit slot most recently emitted, 0..31

## Operation

- Slot counter `k` (5 bit) is internal state. On each clk_pixel with data_island_period=1, slot `k` is emitted and `k` increments, wrapping 31→0.
- At `k`=0, header and sub are captured into shadow registers. Slot 0 uses the live inputs, and slots 1..31 use the shadow. Upstream changes after slot 0 never corrupt the packet in flight.
- Header lane:
  - Slots 0..23 carry header bit `k`.
  - Slots 24..31 carry header ECC bit `k`-24.
- Subpacket lanes (each i independently):
  - Slots 0..27 carry sub[i] bits 2k (even) and 2k+1 (odd).
  - Slots 28..31 carry sub[i] ECC bits 2(k-28) and 2(k-28)+1.
- ECC definition:
  - Generator x^8+x^7+x^6+1, bit-serial, LSB first.
  - Per data bit b: if ecc[0]^b then ecc ← (ecc>>1)^8'h83, else ecc ← ecc>>1.
  - Initial ecc = 0 at slot 0.
- Header ECC takes 1 step per slot over slots 0..23.
- Each subpacket ECC takes 2 steps per slot (even bit first, then odd) over slots 0..27.
- Five ECC registers of 8 bits each; the ECC state is frozen during the parity slots.
- data_island_period low mid-packet (`k`≠0) aborts the packet:
  - `k`←0 and ECCs cleared.
  - The next assertion restarts at slot 0 with freshly captured inputs.
  - No partial packet is resumed.

## Timing

- Reset: packet_data=0, packet_valid=0, packet_loaded=0, counter=0, `k`=0, all ECCs=0, shadows=0.
- Outputs are registered. The cycle with data_island_period=1 and internal `k`=n produces, after the next edge:
  - packet_data = slot n bits
  - packet_valid=1
  - counter=n
- Latency is 1 clock from the slot cycle.
- packet_loaded=1 in the cycle after slot 0 was emitted, and 0 otherwise.
- Cycle after data_island_period=0: packet_valid=0, packet_data=0, and counter keeps its last value.
- Back-to-back packets: slot 31 is followed directly by slot 0 of the next packet, with no bubble. ECC restarts from 0.
- Reset asserted mid-packet overrides everything: all state returns to reset values at the next edge.

## Test plan

- **All-zero packet:** header=0, sub=0, 32 cycles of data_island_period → packet_data=0 for 32 slots; packet_valid high 32 cycles; packet_loaded pulses once, with the slot 0 output; counter steps 0..31.
- **Header ECC:** header=24'h800000, sub=0 → header lane 0 for slots 0..22 and 1 at slot 23. Slots 24..31 header bits are 1,1,0,0,0,0,0,1 (ECC 8'h83). Subpacket lanes stay 0.
- **Subpacket ECC:** sub[0]=56'h80_0000_0000_0000 (bit 55 only), others 0 → packet_data[5]=1 at slot 27 only among data slots. Parity (even,odd) pairs on bits [1],[5]:
  - slot 28: (1,1)
  - slot 29: (0,0)
  - slot 30: (0,0)
  - slot 31: (0,1)
  - lanes for sub[1..3] remain 0.
- **Shadow capture:** present header=24'h800000, then change header to 0 after slot 0 → the output is identical to the header ECC case.
- **Back-to-back:** 64 continuous cycles with the header ECC packet then the all-zero packet →
  - second packet's header parity is 0
  - packet_loaded pulses exactly twice, 32 cycles apart
- **Abort and reset:** drop data_island_period at slot 10, reassert with the header ECC packet → restart at counter=0 and output the full correct packet. Assert reset at slot 5 → all outputs 0 the next cycle.
